framebuffer_scanout: RTL and testbench
======================================

FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33; WORDS_PER_LINE = H_ACTIVE/2 (derived).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port pix_en, input, 1, pixel-clock enable; all timing advances only on cycles with pix_en=1.
REQ-005 SHALL have port frame_base, input, 20, SRAM word address of framebuffer line 0.
REQ-006 SHALL have port ram_request, output, SramRequest_t: address 20, dout 18, den, we_n, oe_n.
REQ-007 SHALL have port ram_result, input, SramResult_t: din 18 {pixelOdd[17:9], pixelEven[8:0]}, done.
REQ-008 SHALL have port vga_color, output, 9, RGB 3:3:3.
REQ-009 SHALL have ports vga_hsync and vga_vsync, output, 1 each, active-low sync.
REQ-010 SHALL have port underrun, output, 1, one-clk pulse when a line is displayed before its fetch completed.

Function
REQ-011 h_count SHALL run 0..799 and v_count 0..524, advancing on pix_en; h wraps to 0 and v increments at h=799; v wraps to 0 at 524.
REQ-012 hsync SHALL be low for h in [656,751]; vsync low for v in [490,491]; active video SHALL be h<640 and v<480.
REQ-013 Two line buffers of WORDS_PER_LINE x 18 bits SHALL be used ping-pong; display reads buffer disp_sel, fetch writes !disp_sel.
REQ-014 frame_base SHALL be latched into base_q at the pix_en cycle with h=0, v=524.
REQ-015 A fetch of line L SHALL start at the pix_en cycle with h=0, where L=v+1 for v in 0..478, L=0 for v=524; no fetch starts otherwise.
REQ-016 disp_sel SHALL toggle at every pix_en cycle with h=0 that starts a fetch, before the fetch writes begin.
REQ-017 Fetch word k SHALL use address base_q + L*WORDS_PER_LINE + k (20-bit, wraps modulo 2^20), k = 0..WORDS_PER_LINE-1.
REQ-018 Fetch FSM states: IDLE, REQ, DONE_WAIT.
  - IDLE -> REQ on fetch start, k=0.
  - REQ: den=1, oe_n=0, we_n=1, address held stable; on ram_result.done store din at buffer[k], go to DONE_WAIT.
  - DONE_WAIT: den=0 for one clk; if k=WORDS_PER_LINE-1 -> IDLE, else k+1 and -> REQ.
REQ-019 In IDLE and DONE_WAIT, den=0, we_n=1, oe_n=1; dout SHALL be 0 always.
REQ-020 If a fetch start occurs while FSM is not IDLE: underrun SHALL pulse one clk; the in-flight request SHALL complete (wait for done, discard data); the FSM SHALL then restart at k=0 for the new line.
REQ-021 Output pipeline latency SHALL be one pix_en: at a pix_en cycle with active (h,v), vga_color <= h[0] ? buffer[h>>1].odd : .even, else 0; hsync/vsync SHALL be registered on the same enable so all three stay aligned.
REQ-022 Unfetched buffer words SHALL display their previous contents; no blanking substitution on underrun.
REQ-023 pix_en=0 SHALL freeze counters and outputs; fetch FSM SHALL run every clk regardless of pix_en.

Reset
REQ-024 On rst: h_count=0, v_count=0, disp_sel=0, base_q=0, FSM IDLE, k=0, vga_color=0, vga_hsync=1, vga_vsync=1, underrun=0, den=0, we_n=1, oe_n=1, address=0.
REQ-025 Reset mid-fetch SHALL abandon the request immediately; buffer contents SHALL be undefined until refetched; first valid frame SHALL follow the first v=524 pass.

Verification
REQ-026 Free-run pix_en=1 2 frames -> hsync low 96 clocks starting at h=656; vsync low for exactly 1600 pix_en cycles per frame; period 420000.
REQ-027 frame_base=0x01000, SRAM model done 1 clk after den, data=address -> at h=0,v=524 first request addr 0x01000; line 1 fetch starts at h=0,v=0 with addr 0x01140; pixel (h=3,v=1) color = odd field of word 0x01141.
REQ-028 SRAM done delayed 3 clks, pix_en every 4th clk -> 320 words complete within 800 pixels; underrun never asserted.
REQ-029 SRAM done withheld past next h=0 -> underrun one-clk pulse; in-flight request finishes; next request addr = new line start.
REQ-030 Change frame_base mid-frame to 0x20000 -> current frame unchanged; next frame line 0 fetches from 0x20000.
REQ-031 Assert rst during REQ with den=1 -> den=0, hsync=vsync=1, vga_color=0 same clk (async); normal fetch resumes at h=0,v=524.

Source files
------------

// File: rtl/framebuffer_scanout_if.sv
// SRAM request/result bundle shared by the scanout engine and the memory side.
package framebuffer_scanout_pkg;
    typedef struct packed {
        logic [19:0] address;
        logic [17:0] dout;
        logic        den;
        logic        we_n;
        logic        oe_n;
    } SramRequest_t;

    typedef struct packed {
        logic [17:0] din;
        logic        done;
    } SramResult_t;
endpackage

interface framebuffer_scanout_if;
    import framebuffer_scanout_pkg::*;
    SramRequest_t ram_request;
    SramResult_t  ram_result;

    modport master (output ram_request, input ram_result);
    modport slave  (input ram_request, output ram_result);
endinterface

// File: rtl/framebuffer_scanout.sv
// VGA scanout: raster timing, ping-pong line buffers filled from SRAM one line ahead.
// state     | meaning
// IDLE      | no line fetch in progress
// REQ       | SRAM read outstanding, waiting for done
// DONE_WAIT | one idle clk between words; decides next word, finish or restart
module framebuffer_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    input  logic [19:0]           frame_base,
    framebuffer_scanout_if.master sram,
    output logic [8:0]            vga_color,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic                  underrun
);
    import framebuffer_scanout_pkg::*;

    localparam int WORDS_PER_LINE = H_ACTIVE / 2;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int KW = $clog2(WORDS_PER_LINE);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE_WAIT} fetchState_t;

    fetchState_t     state, stateNext;
    logic [HW-1:0]   hCount;
    logic [VW-1:0]   vCount;
    logic            dispSel;
    logic [19:0]     baseQ;
    logic [19:0]     lineStart, lineStartNext;
    logic [19:0]     pendStart, pendStartNext;
    logic            restartPend, restartPendNext;
    logic [KW-1:0]   wordIdx, wordIdxNext;
    logic            bufWe;
    logic            fetchStart;
    logic            newFrame;
    logic            active;
    logic [19:0]     newLineStart;
    logic [17:0]     dispWord;
    logic [17:0]     lineBuf [2][WORDS_PER_LINE];

    assign newFrame   = pix_en && (hCount == '0) && (vCount == V_LAST);
    assign fetchStart = pix_en && (hCount == '0) &&
                        ((vCount < VW'(V_ACTIVE - 1)) || (vCount == V_LAST));
    assign active     = (hCount < HW'(H_ACTIVE)) && (vCount < VW'(V_ACTIVE));
    // Line 0 uses frame_base directly since base_q is being loaded on the same cycle.
    assign newLineStart = (vCount == V_LAST) ? frame_base :
                          baseQ + (20'(vCount) + 20'd1) * 20'(WORDS_PER_LINE);
    // Read through the toggle so pixel 0 of a line already sees the new display buffer.
    assign dispWord = lineBuf[dispSel ^ fetchStart][KW'(hCount >> 1)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hCount    <= '0;
            vCount    <= '0;
            dispSel   <= 1'b0;
            baseQ     <= '0;
            vga_color <= '0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            if (pix_en) begin
                if (hCount == H_LAST) begin
                    hCount <= '0;
                    vCount <= (vCount == V_LAST) ? '0 : vCount + 1'b1;
                end else begin
                    hCount <= hCount + 1'b1;
                end
                if (newFrame) baseQ <= frame_base;
                vga_color <= active ? (hCount[0] ? dispWord[17:9] : dispWord[8:0]) : 9'd0;
                vga_hsync <= !((hCount >= HS_START) && (hCount <= HS_END));
                vga_vsync <= !((vCount >= VS_START) && (vCount <= VS_END));
            end
            if (fetchStart) dispSel <= ~dispSel;
        end
    end

    always_ff @(posedge clk) begin
        if (bufWe) lineBuf[~dispSel][wordIdx] <= sram.ram_result.din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wordIdx     <= '0;
            lineStart   <= '0;
            pendStart   <= '0;
            restartPend <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= stateNext;
            wordIdx     <= wordIdxNext;
            lineStart   <= lineStartNext;
            pendStart   <= pendStartNext;
            restartPend <= restartPendNext;
            underrun    <= fetchStart && (state != IDLE);
        end
    end

    always_comb begin
        stateNext       = state;
        wordIdxNext     = wordIdx;
        lineStartNext   = lineStart;
        pendStartNext   = pendStart;
        restartPendNext = restartPend;
        bufWe           = 1'b0;
        case (state)
            IDLE: begin
                if (fetchStart) begin
                    stateNext     = REQ;
                    wordIdxNext   = '0;
                    lineStartNext = newLineStart;
                end
            end
            REQ: begin
                // A late request must still finish on the bus; its data belongs to a stale line.
                if (fetchStart) begin
                    restartPendNext = 1'b1;
                    pendStartNext   = newLineStart;
                end
                if (sram.ram_result.done) begin
                    bufWe     = !restartPend && !fetchStart;
                    stateNext = DONE_WAIT;
                end
            end
            DONE_WAIT: begin
                if (fetchStart || restartPend) begin
                    stateNext       = REQ;
                    wordIdxNext     = '0;
                    lineStartNext   = fetchStart ? newLineStart : pendStart;
                    restartPendNext = 1'b0;
                end else if (wordIdx == K_LAST) begin
                    stateNext = IDLE;
                end else begin
                    wordIdxNext = wordIdx + 1'b1;
                    stateNext   = REQ;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        sram.ram_request.address = lineStart + 20'(wordIdx);
        sram.ram_request.dout    = '0;
        sram.ram_request.den     = (state == REQ);
        sram.ram_request.we_n    = 1'b1;
        sram.ram_request.oe_n    = (state != REQ);
    end
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout on a scaled-down raster (48x14 total, 32x8 active).
module tb_framebuffer_scanout;
    localparam int H_ACTIVE = 32, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_ACTIVE = 8, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int H_TOTAL = 48, V_TOTAL = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic [19:0] frame_base = '0;
    logic [8:0]  vga_color;
    logic        vga_hsync, vga_vsync, underrun;

    framebuffer_scanout_if sram();

    framebuffer_scanout #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_en(pix_en),
        .frame_base(frame_base),
        .sram(sram),
        .vga_color(vga_color),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int testsRun = 0, testsFailed = 0;
    int pixDiv = 1, divCnt = 0, lat = 1, memCnt = 0, rstFrame = 0;
    bit withhold = 0;

    int hm = 0, vm = 0, lastH = -1, lastV = -1, frameNum = 0, pixIdx = 0;
    int armFrame = 0, armV = 0, wordsCnt = 0, lastFetchWords = 0;
    int underrunCnt = 0, underrunLong = 0;
    int hsRun = 0, hsRunLast = 0, hsFallH = -1, vsLowCnt = 0, vsFallCnt = 0, vsFall0 = 0, vsFall1 = 0;
    bit rstNext = 1, denPrev = 0, undPrev = 0, hsPrev = 1, vsPrev = 1, fetchArmed = 0, postU = 0;
    logic [19:0] addrPrev = '0;
    logic [19:0] postUDoneAddr = 20'hfffff;
    logic [19:0] startAddr [6][V_TOTAL];
    logic [8:0]  colorCap [6][4][H_ACTIVE];
    logic [8:0]  inactCap [6];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitAt(input int f, input int v, input int h, input int limit, input string tag);
        int i = 0;
        while (!(frameNum == f && lastV == v && lastH == h) && i < limit) begin
            @(posedge clk); #2;
            i++;
        end
        check(tag, 32'(i < limit), 32'd1);
    endtask

    // Raster model, monitors, SRAM model and pix_en generation, all on the falling edge.
    initial begin
        sram.ram_result = '0;
        forever begin
            @(negedge clk);
            if (sram.ram_result.done && denPrev) begin
                wordsCnt++;
                if (postU) begin
                    postUDoneAddr = addrPrev;
                    postU = 0;
                end
            end
            if (pix_en && !rstNext) begin
                lastH = hm; lastV = vm; pixIdx++;
                if (hm == 0 && (vm < V_ACTIVE - 1 || vm == V_TOTAL - 1)) begin
                    fetchArmed = 1; armFrame = frameNum; armV = vm;
                    lastFetchWords = wordsCnt; wordsCnt = 0;
                end
                if (vm < 4 && hm < H_ACTIVE) colorCap[frameNum][vm][hm] = vga_color;
                if (vm == 1 && hm == 40) inactCap[frameNum] = vga_color;
                if (frameNum < 2) begin
                    if (!vga_vsync) vsLowCnt++;
                    if (!vga_vsync && vsPrev) begin
                        if (vsFallCnt == 0) vsFall0 = pixIdx; else vsFall1 = pixIdx;
                        vsFallCnt++;
                    end
                    if (!vga_hsync) begin
                        if (hsPrev) hsFallH = hm;
                        hsRun++;
                    end else if (hsRun > 0) begin
                        hsRunLast = hsRun; hsRun = 0;
                    end
                end
                hsPrev = vga_hsync; vsPrev = vga_vsync;
                if (hm == H_TOTAL - 1) begin
                    hm = 0;
                    if (vm == V_TOTAL - 1) begin vm = 0; frameNum++; end
                    else vm++;
                end else hm++;
            end
            if (rst) begin hm = 0; vm = 0; frameNum = rstFrame; fetchArmed = 0; end
            if (sram.ram_request.den && !denPrev && fetchArmed) begin
                startAddr[armFrame][armV] = sram.ram_request.address;
                fetchArmed = 0;
            end
            if (underrun) begin
                underrunCnt++;
                if (undPrev) underrunLong++; else postU = 1;
            end
            undPrev = underrun;
            if (sram.ram_request.den) begin
                memCnt++;
                if (memCnt >= lat && !withhold) begin
                    sram.ram_result.done = 1'b1;
                    sram.ram_result.din  = sram.ram_request.address[17:0];
                end else sram.ram_result.done = 1'b0;
            end else begin
                memCnt = 0;
                sram.ram_result.done = 1'b0;
            end
            denPrev = sram.ram_request.den; addrPrev = sram.ram_request.address;
            rstNext = rst;
            pix_en = (divCnt == 0);
            divCnt = (divCnt + 1 >= pixDiv) ? 0 : divCnt + 1;
        end
    end

    initial begin
        rst = 1'b1;
        frame_base = 20'h01000;
        repeat (3) @(posedge clk);
        #2;
        check("rst_color", 32'(vga_color), 32'h0);
        check("rst_hsync", 32'(vga_hsync), 32'h1);
        check("rst_vsync", 32'(vga_vsync), 32'h1);
        check("rst_underrun", 32'(underrun), 32'h0);
        check("rst_den", 32'(sram.ram_request.den), 32'h0);
        check("rst_we_n", 32'(sram.ram_request.we_n), 32'h1);
        check("rst_oe_n", 32'(sram.ram_request.oe_n), 32'h1);
        check("rst_address", 32'(sram.ram_request.address), 32'h0);
        check("rst_dout", 32'(sram.ram_request.dout), 32'h0);
        rst = 1'b0;

        waitAt(1, 5, 0, 2000, "wait_f1v5");
        frame_base = 20'h20000;
        waitAt(2, 1, 0, 2000, "wait_f2v1");
        pixDiv = 4; lat = 3;
        check("hsync_fall_h", 32'(hsFallH), 32'd36);
        check("hsync_low_len", 32'(hsRunLast), 32'd8);
        check("vsync_low_2frames", 32'(vsLowCnt), 32'd192);
        check("vsync_period", 32'(vsFall1 - vsFall0), 32'd672);
        check("addr_f0_line1_base0", 32'(startAddr[0][0]), 32'h00010);
        check("addr_f0_line0", 32'(startAddr[0][13]), 32'h01000);
        check("addr_f1_line1", 32'(startAddr[1][0]), 32'h01010);
        check("addr_f1_line7_after_base_chg", 32'(startAddr[1][6]), 32'h01070);
        check("addr_f1_next_line0", 32'(startAddr[1][13]), 32'h20000);
        check("addr_f2_line1", 32'(startAddr[2][0]), 32'h20010);
        check("pix_f1_h2v1", 32'(colorCap[1][1][2]), 32'h011);
        check("pix_f1_h3v1", 32'(colorCap[1][1][3]), 32'h008);
        check("pix_f1_h6v1", 32'(colorCap[1][1][6]), 32'h013);
        check("pix_f1_blank", 32'(inactCap[1]), 32'h0);
        check("no_underrun_fast", 32'(underrunCnt), 32'd0);

        waitAt(3, 2, 40, 6000, "wait_f3v2");
        check("pix_f2_h4v2_slow", 32'(colorCap[2][2][4]), 32'h022);
        check("pix_f2_h5v2_slow", 32'(colorCap[2][2][5]), 32'h100);
        check("words_per_line_slow", 32'(lastFetchWords), 32'd16);
        check("no_underrun_slow", 32'(underrunCnt), 32'd0);
        check("addr_f3_line2", 32'(startAddr[3][1]), 32'h20020);
        withhold = 1;

        waitAt(3, 4, 2, 2000, "wait_f3v4");
        check("underrun_count", 32'(underrunCnt), 32'd1);
        check("underrun_one_clk", 32'(underrunLong), 32'd0);
        check("inflight_den_held", 32'(sram.ram_request.den), 32'h1);
        check("inflight_addr_held", 32'(sram.ram_request.address), 32'h20040);
        check("addr_f3_line4", 32'(startAddr[3][3]), 32'h20040);
        withhold = 0;
        repeat (20) @(posedge clk);
        #2;
        check("inflight_completed_addr", 32'(postUDoneAddr), 32'h20040);
        check("restart_addr_line5", 32'(startAddr[3][4]), 32'h20050);

        begin
            int i = 0;
            while (sram.ram_request.den !== 1'b1 && i < 400) begin
                @(posedge clk); #2;
                i++;
            end
            check("wait_den_for_reset", 32'(sram.ram_request.den), 32'h1);
        end
        rstFrame = 4;
        rst = 1'b1;
        #1;
        check("async_rst_den", 32'(sram.ram_request.den), 32'h0);
        check("async_rst_oe_n", 32'(sram.ram_request.oe_n), 32'h1);
        check("async_rst_address", 32'(sram.ram_request.address), 32'h0);
        check("async_rst_hsync", 32'(vga_hsync), 32'h1);
        check("async_rst_vsync", 32'(vga_vsync), 32'h1);
        check("async_rst_color", 32'(vga_color), 32'h0);
        check("async_rst_underrun", 32'(underrun), 32'h0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        waitAt(5, 2, 0, 8000, "wait_f5v2");
        check("post_rst_line1_base0", 32'(startAddr[4][0]), 32'h00010);
        check("post_rst_line0", 32'(startAddr[4][13]), 32'h20000);
        check("post_rst_f5_line1", 32'(startAddr[5][0]), 32'h20010);
        check("post_rst_pix_h2v1", 32'(colorCap[5][1][2]), 32'h011);
        check("post_rst_pix_h3v1", 32'(colorCap[5][1][3]), 32'h100);
        check("post_rst_underrun_count", 32'(underrunCnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
